// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: issues I-cache word reads for the current PC and queues
// the returned instructions (with PC and fault flag) toward decode.
module fetch_buffer #(
    parameter int          DEPTH       = 2,
    parameter int          IMEM_ADDR_W = 12,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic                   ip_clk,
    input  logic                   ip_rst,
    input  logic [31:0]            ip_pc,
    input  logic                   ip_flush,
    input  logic                   ip_decode_ready,
    input  logic [31:0]            ip_imem_rdata,
    output logic                   op_imem_en,
    output logic [IMEM_ADDR_W-1:0] op_imem_addr,
    output logic                   op_stall_pc,
    output logic                   op_valid,
    output logic [31:0]            op_instr,
    output logic [31:0]            op_instr_pc,
    output logic                   op_fault
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW:0]     count;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            req_valid;
    logic [31:0]     req_pc;
    logic            req_fault;

    logic            empty, pop, push, issue, in_range, misaligned;
    logic [AW+1:0]   occ;
    entry_t          head;

    always_comb begin
        empty        = (count == '0);
        head         = mem[rd_ptr];
        op_valid     = ~empty & ~ip_flush;
        pop          = op_valid & ip_decode_ready;
        push         = req_valid & ~ip_flush;
        // Occupancy as it will stand after this edge, counting the read in flight.
        occ          = {1'b0, count} + (AW+2)'(req_valid) - (AW+2)'(pop);
        op_stall_pc  = ~ip_rst & ~ip_flush & (occ >= (AW+2)'(DEPTH));
        in_range     = (ip_pc[31:IMEM_ADDR_W+2] == '0);
        misaligned   = (ip_pc[1:0] != 2'b00);
        issue        = ~ip_rst & ~ip_flush & ~op_stall_pc & in_range;
        op_imem_en   = issue & ~misaligned;
        op_imem_addr = ip_pc[IMEM_ADDR_W+1:2];
        op_instr     = empty ? NOP_INSTR : head.instr;
        op_instr_pc  = empty ? 32'h0 : head.pc;
        op_fault     = empty ? 1'b0 : head.fault;
    end

    always_ff @(posedge ip_clk) begin
        if (ip_rst) begin
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            req_valid <= 1'b0;
            req_pc    <= '0;
            req_fault <= 1'b0;
        end else begin
            req_valid <= issue;
            req_pc    <= ip_pc;
            req_fault <= misaligned;
            if (ip_flush) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                count <= count + (AW+1)'(push) - (AW+1)'(pop);
            end
        end
    end

    // I-cache data is only valid in the response cycle, so capture it straight into the slot.
    always_ff @(posedge ip_clk) begin
        if (push)
            mem[wr_ptr] <= '{pc: req_pc, instr: (req_fault ? NOP_INSTR : ip_imem_rdata), fault: req_fault};
    end

endmodule
